// File: rtl/apb_master_arbiter.sv
// ---------------------------------------------------------------------------
// apb_master_arbiter
//
// Two-requester APB arbiter. Each requester is an APB master (m0_*, m1_*);
// the arbiter owns a single shared APB master port (apb_*) towards one slave.
// A requester holding psel is considered pending. In IDLE a winner is
// chosen, its address/direction/write data are captured, and a standard
// SETUP -> ACCESS transfer is run on the shared bus. The winner sees the
// slave's pready/prdata only while the bus is in ACCESS; the other requester
// is stalled (pready_o = 0, prdata_o = 0) until a later IDLE arbitration.
//
// Build option:
//   APB_ARB_ROUND_ROBIN_EN  defined   -> simultaneous requests go to the port
//                                        that did not win last time.
//                           undefined -> fixed priority, port 0 wins ties.
//
// Ports:
//   apb_pclk_i, apb_preset_i           clock, asynchronous active-high reset
//   mN_psel_i/penable_i/pwrite_i       requester N controls (penable ignored)
//   mN_paddr_i, mN_pwdata_i            requester N address / write data
//   mN_prdata_o, mN_pready_o           requester N read data / completion
//   apb_psel_o/penable_o/pwrite_o      shared bus controls
//   apb_paddr_o, apb_pwdata_o          shared bus address / write data
//   apb_prdata_i, apb_pready_i         shared bus slave response
// ---------------------------------------------------------------------------
module apb_master_arbiter #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int APB_DATA_WIDTH = 8
) (
  input  logic                      apb_pclk_i,
  input  logic                      apb_preset_i,

  input  logic                      m0_psel_i,
  input  logic                      m0_penable_i,
  input  logic                      m0_pwrite_i,
  input  logic [APB_ADDR_WIDTH-1:0] m0_paddr_i,
  input  logic [APB_DATA_WIDTH-1:0] m0_pwdata_i,
  output logic [APB_DATA_WIDTH-1:0] m0_prdata_o,
  output logic                      m0_pready_o,

  input  logic                      m1_psel_i,
  input  logic                      m1_penable_i,
  input  logic                      m1_pwrite_i,
  input  logic [APB_ADDR_WIDTH-1:0] m1_paddr_i,
  input  logic [APB_DATA_WIDTH-1:0] m1_pwdata_i,
  output logic [APB_DATA_WIDTH-1:0] m1_prdata_o,
  output logic                      m1_pready_o,

  output logic                      apb_psel_o,
  output logic                      apb_penable_o,
  output logic                      apb_pwrite_o,
  output logic [APB_ADDR_WIDTH-1:0] apb_paddr_o,
  output logic [APB_DATA_WIDTH-1:0] apb_pwdata_o,
  input  logic [APB_DATA_WIDTH-1:0] apb_prdata_i,
  input  logic                      apb_pready_i
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  logic [1:0]                state_q, state_d;
  logic                      grant_q, grant_d;
  logic                      last_grant_q, last_grant_d;
  logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [APB_DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                      pwrite_q, pwrite_d;

  logic                      any_req;
  logic                      winner;
  logic                      in_access;

  // penable from the requesters plays no part in arbitration.
  logic unused_penable;
  assign unused_penable = m0_penable_i ^ m1_penable_i;

  assign any_req = m0_psel_i | m1_psel_i;

  // Winner selection. A sole requester always wins; only the tie case
  // differs between the two builds.
  always_comb begin
    winner = ~m0_psel_i;
`ifdef APB_ARB_ROUND_ROBIN_EN
    if (m0_psel_i && m1_psel_i) begin
      winner = ~last_grant_q;
    end
`endif
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    paddr_d      = paddr_q;
    pwdata_d     = pwdata_q;
    pwrite_d     = pwrite_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d      = ST_SETUP;
          grant_d      = winner;
          last_grant_d = winner;
          paddr_d      = winner ? m1_paddr_i  : m0_paddr_i;
          pwdata_d     = winner ? m1_pwdata_i : m0_pwdata_i;
          pwrite_d     = winner ? m1_pwrite_i : m0_pwrite_i;
        end
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        // The transfer runs to completion even if the granted requester
        // drops psel part way through; there is no abort path.
        if (apb_pready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge apb_pclk_i or posedge apb_preset_i) begin
    if (apb_preset_i) begin
      state_q      <= ST_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      paddr_q      <= '0;
      pwdata_q     <= '0;
      pwrite_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      paddr_q      <= paddr_d;
      pwdata_q     <= pwdata_d;
      pwrite_q     <= pwrite_d;
    end
  end

  // Bus controls decode straight from the registered state, so reset
  // clears them in the same cycle it is asserted.
  assign in_access     = (state_q == ST_ACCESS);
  assign apb_psel_o    = (state_q == ST_SETUP) | in_access;
  assign apb_penable_o = in_access;
  assign apb_paddr_o   = paddr_q;
  assign apb_pwdata_o  = pwdata_q;
  assign apb_pwrite_o  = pwrite_q;

  // Response routing is combinational from the slave so the winner sees
  // pready in the very cycle the slave completes.
  always_comb begin
    m0_pready_o = 1'b0;
    m1_pready_o = 1'b0;
    m0_prdata_o = '0;
    m1_prdata_o = '0;
    if (in_access) begin
      if (grant_q) begin
        m1_pready_o = apb_pready_i;
        m1_prdata_o = apb_prdata_i;
      end else begin
        m0_pready_o = apb_pready_i;
        m0_prdata_o = apb_prdata_i;
      end
    end
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// ---------------------------------------------------------------------------
// tb_apb_master_arbiter
//
// Directed and randomized bench for apb_master_arbiter. Each episode states
// how many back-to-back transfers each requester wants; a transaction-level
// model picks the winner order from the arbitration rules and the bench
// checks every bus cycle (IDLE sample, SETUP, each ACCESS cycle) against the
// winner's captured fields and the slave response it drives.
// ---------------------------------------------------------------------------
module tb_apb_master_arbiter;

  logic        clk = 1'b0;
  logic        rst;

  logic        m0_psel, m0_penable, m0_pwrite;
  logic [11:0] m0_paddr;
  logic [7:0]  m0_pwdata, m0_prdata;
  logic        m0_pready;

  logic        m1_psel, m1_penable, m1_pwrite;
  logic [11:0] m1_paddr;
  logic [7:0]  m1_pwdata, m1_prdata;
  logic        m1_pready;

  logic        apb_psel, apb_penable, apb_pwrite;
  logic [11:0] apb_paddr;
  logic [7:0]  apb_pwdata, apb_prdata;
  logic        apb_pready;

  int tests = 0;
  int fails = 0;

  // Per-requester transaction fields and slave wait states.
  logic [11:0] ad [2];
  logic [7:0]  wd [2];
  logic        wr [2];
  logic [7:0]  rd [2];
  int          wt [2];

  // Model state: which port won the most recent grant.
  logic mdl_last;

  apb_master_arbiter #(.APB_ADDR_WIDTH(12), .APB_DATA_WIDTH(8)) dut (
    .apb_pclk_i   (clk),
    .apb_preset_i (rst),
    .m0_psel_i    (m0_psel),
    .m0_penable_i (m0_penable),
    .m0_pwrite_i  (m0_pwrite),
    .m0_paddr_i   (m0_paddr),
    .m0_pwdata_i  (m0_pwdata),
    .m0_prdata_o  (m0_prdata),
    .m0_pready_o  (m0_pready),
    .m1_psel_i    (m1_psel),
    .m1_penable_i (m1_penable),
    .m1_pwrite_i  (m1_pwrite),
    .m1_paddr_i   (m1_paddr),
    .m1_pwdata_i  (m1_pwdata),
    .m1_prdata_o  (m1_prdata),
    .m1_pready_o  (m1_pready),
    .apb_psel_o   (apb_psel),
    .apb_penable_o(apb_penable),
    .apb_pwrite_o (apb_pwrite),
    .apb_paddr_o  (apb_paddr),
    .apb_pwdata_o (apb_pwdata),
    .apb_prdata_i (apb_prdata),
    .apb_pready_i (apb_pready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; checks happen 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rnd_fields(input int idx);
    ad[idx] = 12'($urandom);
    wd[idx] = 8'($urandom);
    wr[idx] = 1'($urandom);
    rd[idx] = 8'($urandom);
    wt[idx] = $urandom_range(0, 3);
  endtask

  task automatic set_m(input int idx, input logic sel);
    if (idx == 0) begin
      m0_psel = sel; m0_paddr = ad[0]; m0_pwdata = wd[0];
      m0_pwrite = wr[0]; m0_penable = 1'($urandom);
    end else begin
      m1_psel = sel; m1_paddr = ad[1]; m1_pwdata = wd[1];
      m1_pwrite = wr[1]; m1_penable = 1'($urandom);
    end
  endtask

  // Arbitration rule: a sole requester wins; ties go to port 0 (fixed)
  // or to the port that is not the last winner (round robin).
  function automatic logic pick(input int p0, input int p1);
    if (p0 > 0 && p1 > 0) begin
`ifdef APB_ARB_ROUND_ROBIN_EN
      return ~mdl_last;
`else
      return 1'b0;
`endif
    end
    return (p0 > 0) ? 1'b0 : 1'b1;
  endfunction

  function automatic logic [7:0] prd_of(input int idx);
    return (idx == 0) ? m0_prdata : m1_prdata;
  endfunction

  function automatic logic prdy_of(input int idx);
    return (idx == 0) ? m0_pready : m1_pready;
  endfunction

  // Called at edge+1ns of an IDLE cycle. n0/n1: transfers wanted by each
  // requester. viol: granted requester drops psel in its first ACCESS cycle.
  // late: m1 only raises psel during m0's first ACCESS cycle.
  task automatic episode(input int n0, input int n1, input bit viol, input bit late);
    int   pend [2];
    bit   act1;
    logic w;
    int   o;
    logic [7:0] pd;
    pend[0] = n0;
    pend[1] = n1;
    act1 = !late;
    set_m(0, n0 > 0);
    set_m(1, (n1 > 0) && act1);
    while (pend[0] > 0 || pend[1] > 0) begin
      w = pick(pend[0], act1 ? pend[1] : 0);
      mdl_last = w;
      o = (w == 1'b0) ? 1 : 0;
      #1;
      chk("idle_psel", apb_psel, 0);
      chk("idle_penable", apb_penable, 0);
      chk("idle_pready_w", prdy_of(int'(w)), 0);
      tick();
      #1;
      chk("setup_psel", apb_psel, 1);
      chk("setup_penable", apb_penable, 0);
      chk("setup_paddr", apb_paddr, ad[w]);
      chk("setup_pwrite", apb_pwrite, wr[w]);
      chk("setup_pwdata", apb_pwdata, wd[w]);
      chk("setup_pready_w", prdy_of(int'(w)), 0);
      for (int i = 0; i <= wt[w]; i++) begin
        tick();
        pd = (i == wt[w]) ? rd[w] : 8'($urandom);
        apb_pready = (i == wt[w]);
        apb_prdata = pd;
        if (i == 0 && late && !act1) begin
          act1 = 1'b1;
          set_m(1, 1'b1);
        end
        if (i == 0 && viol && pend[w] == 1) set_m(int'(w), 1'b0);
        #1;
        chk("acc_psel", apb_psel, 1);
        chk("acc_penable", apb_penable, 1);
        chk("acc_paddr", apb_paddr, ad[w]);
        chk("acc_pwrite", apb_pwrite, wr[w]);
        chk("acc_pwdata", apb_pwdata, wd[w]);
        chk("acc_pready_w", prdy_of(int'(w)), (i == wt[w]) ? 1 : 0);
        chk("acc_prdata_w", prd_of(int'(w)), pd);
        chk("acc_pready_other", prdy_of(o), 0);
        chk("acc_prdata_other", prd_of(o), 0);
      end
      tick();
      apb_pready = 1'b0;
      apb_prdata = 8'($urandom);
      pend[w]--;
      if (pend[w] > 0) begin
        rnd_fields(int'(w));
        set_m(int'(w), 1'b1);
      end else begin
        set_m(int'(w), 1'b0);
      end
    end
    #1;
    chk("end_idle_psel", apb_psel, 0);
    chk("end_pready0", m0_pready, 0);
    chk("end_pready1", m1_pready, 0);
    tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_psel"}, apb_psel, 0);
    chk({tag, "_penable"}, apb_penable, 0);
    chk({tag, "_pwrite"}, apb_pwrite, 0);
    chk({tag, "_paddr"}, apb_paddr, 0);
    chk({tag, "_pwdata"}, apb_pwdata, 0);
    chk({tag, "_pready0"}, m0_pready, 0);
    chk({tag, "_pready1"}, m1_pready, 0);
    chk({tag, "_prdata0"}, m0_prdata, 0);
    chk({tag, "_prdata1"}, m1_prdata, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    apb_pready = 1'b1;
    apb_prdata = 8'hFF;
    m0_psel = 1'b0;
    m1_psel = 1'b0;
    tick();
    #1;
    check_reset_outputs("rst");
    tick();
    rst = 1'b0;
    apb_pready = 1'b0;
    mdl_last = 1'b1;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    m0_psel = 0; m0_penable = 0; m0_pwrite = 0; m0_paddr = 0; m0_pwdata = 0;
    m1_psel = 0; m1_penable = 0; m1_pwrite = 0; m1_paddr = 0; m1_pwdata = 0;
    apb_pready = 0; apb_prdata = 0;
    mdl_last = 1'b1;
    rnd_fields(0);
    rnd_fields(1);
    do_reset();

    // m0 write 0x123/0xA5, slave ready on first ACCESS cycle.
    ad[0] = 12'h123; wd[0] = 8'hA5; wr[0] = 1'b1; wt[0] = 0;
    episode(1, 0, 1'b0, 1'b0);

    // m1 read 0x040, three wait states, returns 0x5C.
    ad[1] = 12'h040; wr[1] = 1'b0; rd[1] = 8'h5C; wt[1] = 3;
    episode(0, 1, 1'b0, 1'b0);

    // Simultaneous requests straight after reset, twice.
    do_reset();
    rnd_fields(0); rnd_fields(1);
    episode(1, 1, 1'b0, 1'b0);
    rnd_fields(0); rnd_fields(1);
    episode(1, 1, 1'b0, 1'b0);

    // m0 keeps requesting while m1 waits.
    rnd_fields(0); rnd_fields(1);
    episode(2, 1, 1'b0, 1'b0);

    // m1 arrives during m0's ACCESS.
    rnd_fields(0); rnd_fields(1);
    wt[0] = 2;
    episode(1, 1, 1'b0, 1'b1);

    // Granted requester drops psel mid-transfer; transfer still completes.
    rnd_fields(0); rnd_fields(1);
    wt[1] = 2;
    episode(0, 1, 1'b1, 1'b0);

    // Reset pulsed during ACCESS with the slave not ready.
    rnd_fields(0);
    set_m(0, 1'b1);
    tick();
    tick();
    apb_pready = 1'b0;
    #1;
    chk("pre_rst_penable", apb_penable, 1);
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    apb_pready = 1'b1;
    #1;
    chk("midrst_pready0", m0_pready, 0);
    chk("midrst_pready1", m1_pready, 0);
    tick();
    rst = 1'b0;
    apb_pready = 1'b0;
    set_m(0, 1'b0);
    mdl_last = 1'b1;
    tick();
    rnd_fields(0); rnd_fields(1);
    episode(1, 1, 1'b0, 1'b0);

    // Randomized episodes.
    for (int k = 0; k < 40; k++) begin
      int  n0, n1;
      bit  late;
      n0 = $urandom_range(0, 2);
      n1 = $urandom_range(0, 2);
      if (n0 == 0 && n1 == 0) n1 = 1;
      late = (n0 > 0 && n1 > 0) ? 1'($urandom) : 1'b0;
      rnd_fields(0); rnd_fields(1);
      episode(n0, n1, 1'($urandom), late);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
